// File: rtl/game_pkg.sv
// Shared definitions for the game blocks: game state encoding and default
// timing constants for the speed clock.
package game_pkg;

  typedef enum logic [1:0] {
    GS_INIT  = 2'd0,
    GS_START = 2'd1,
    GS_END   = 2'd2,
    GS_RESET = 2'd3
  } game_state_e;

  localparam int DEF_CNT_W             = 28;
  localparam int DEF_DIV_INIT          = 150000;
  localparam int DEF_DIV_MIN           = 118000;
  localparam int DEF_DIV_STEP          = 4000;
  localparam int DEF_TOGGLES_PER_LEVEL = 3500;
  localparam int DEF_LVL_W             = 8;
  localparam int DEF_IDLE_W            = 23;

  // Counter width for 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_speed_clock_if.sv
// Control/status bundle between the game controller (master) and the speed
// clock (slave).
interface game_speed_clock_if import game_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int LVL_W = DEF_LVL_W
);
  game_state_e        game_state;
  logic               pause;
  logic               clk_div;
  logic               tick;
  logic [LVL_W-1:0]   level;
  logic [CNT_W-1:0]   cur_div;
  logic               speed_max;

  modport master (
    output game_state, pause,
    input  clk_div, tick, level, cur_div, speed_max
  );

  modport slave (
    input  game_state, pause,
    output clk_div, tick, level, cur_div, speed_max
  );
endinterface

// File: rtl/idle_prescaler.sv
// Free-running prescaler; its MSB is the slow clock shown outside of play.
module idle_prescaler #(
  parameter int IDLE_W = game_pkg::DEF_IDLE_W
) (
  input  logic clk,
  input  logic rst_n,
  output logic idle_clk
);
  logic [IDLE_W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign idle_clk = cnt_q[IDLE_W-1];
endmodule

// File: rtl/game_speed_clock.sv
// Game tempo generator: divides clk by a divider that shrinks every
// TOGGLES_PER_LEVEL toggles, down to DIV_MIN, while counting levels.
module game_speed_clock import game_pkg::*; #(
  parameter int CNT_W             = DEF_CNT_W,
  parameter int DIV_INIT          = DEF_DIV_INIT,
  parameter int DIV_MIN           = DEF_DIV_MIN,
  parameter int DIV_STEP          = DEF_DIV_STEP,
  parameter int TOGGLES_PER_LEVEL = DEF_TOGGLES_PER_LEVEL,
  parameter int LVL_W             = DEF_LVL_W,
  parameter int IDLE_W            = DEF_IDLE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  game_speed_clock_if.slave bus
);
  localparam int TOG_W = clog2_min1(TOGGLES_PER_LEVEL);
  localparam logic [CNT_W-1:0] DIV_INIT_C = CNT_W'(DIV_INIT);
  localparam logic [CNT_W-1:0] DIV_MIN_C  = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] DIV_STEP_C = CNT_W'(DIV_STEP);
  // One bit wider so DIV_MIN+DIV_STEP near the top of the range cannot wrap.
  localparam logic [CNT_W:0]   STEP_THR   = (CNT_W+1)'(DIV_MIN) + (CNT_W+1)'(DIV_STEP);
  localparam logic [TOG_W-1:0] TOG_LAST   = TOG_W'(TOGGLES_PER_LEVEL - 1);

  if (!(DIV_MIN <= DIV_INIT && longint'(DIV_INIT) < (longint'(1) << CNT_W) &&
        DIV_STEP >= 1 && TOGGLES_PER_LEVEL >= 1)) begin : g_param_err
    $error("game_speed_clock: illegal divider/toggle parameters");
  end

  logic [CNT_W-1:0] counter_q, counter_d;
  logic [TOG_W-1:0] tog_q, tog_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             idle_clk;

  idle_prescaler #(.IDLE_W(IDLE_W)) u_idle (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle_clk (idle_clk)
  );

  always_comb begin
    counter_d = counter_q;
    tog_d     = tog_q;
    cur_div_d = cur_div_q;
    level_d   = level_q;
    clk_div_d = clk_div_q;
    tick_d    = 1'b0;
    case (bus.game_state)
      GS_START: begin
        if (!bus.pause) begin
          if (counter_q < cur_div_q) begin
            counter_d = counter_q + 1'b1;
          end else begin
            counter_d = '0;
            clk_div_d = ~clk_div_q;
            tick_d    = 1'b1;
            if (tog_q == TOG_LAST) begin
              tog_d     = '0;
              cur_div_d = ({1'b0, cur_div_q} >= STEP_THR) ? cur_div_q - DIV_STEP_C : DIV_MIN_C;
              if (level_q != '1) level_d = level_q + 1'b1;
            end else begin
              tog_d = tog_q + 1'b1;
            end
          end
        end
      end
      GS_END: clk_div_d = idle_clk;
      default: begin
        clk_div_d = idle_clk;
        counter_d = '0;
        tog_d     = '0;
        cur_div_d = DIV_INIT_C;
        level_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q <= '0;
      tog_q     <= '0;
      cur_div_q <= DIV_INIT_C;
      level_q   <= '0;
      clk_div_q <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      tog_q     <= tog_d;
      cur_div_q <= cur_div_d;
      level_q   <= level_d;
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.clk_div   = clk_div_q;
  assign bus.tick      = tick_q;
  assign bus.level     = level_q;
  assign bus.cur_div   = cur_div_q;
  assign bus.speed_max = (cur_div_q == DIV_MIN_C);
endmodule

// File: tb/tb_game_speed_clock.sv
// Scoreboard bench: stimulus queues hand-computed toggle expectations, a
// tick monitor pops and compares them; steady-state values are checked inline.
module tb_game_speed_clock;
  import game_pkg::*;

  typedef struct {
    int cyc;
    int clk_div;
    int cur_div;
    int level;
    int smax;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  game_speed_clock_if #(.CNT_W(8), .LVL_W(2)) bus_a ();
  game_speed_clock_if #(.CNT_W(8), .LVL_W(2)) bus_b ();

  game_speed_clock #(.CNT_W(8), .DIV_INIT(4), .DIV_MIN(2), .DIV_STEP(1),
                     .TOGGLES_PER_LEVEL(2), .LVL_W(2), .IDLE_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));

  game_speed_clock #(.CNT_W(8), .DIV_INIT(4), .DIV_MIN(2), .DIV_STEP(3),
                     .TOGGLES_PER_LEVEL(2), .LVL_W(2), .IDLE_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Registered idle-clock MSB of a 3-bit prescaler released at cycle r.
  function automatic int idle_exp(input int c, input int r);
    return (((c - r - 1) % 8) >= 4) ? 1 : 0;
  endfunction

  task automatic push(input int c, input int cd, input int dv, input int lv, input int sm);
    exp_t e;
    e = '{cyc: c, clk_div: cd, cur_div: dv, level: lv, smax: sm};
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bus_a.tick) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_tick: tick=1 at cycle %0d, expected no tick", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("tick_cycle", cyc, e.cyc);
        chk("tick_clk_div", int'(bus_a.clk_div), e.clk_div);
        chk("tick_cur_div", int'(bus_a.cur_div), e.cur_div);
        chk("tick_level", int'(bus_a.level), e.level);
        chk("tick_speed_max", int'(bus_a.speed_max), e.smax);
      end
    end
  end

  initial begin
    int s, u, v, hold;
    rst_n = 1'b0;
    bus_a.game_state = GS_INIT; bus_a.pause = 1'b0;
    bus_b.game_state = GS_INIT; bus_b.pause = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk_div", int'(bus_a.clk_div), 1);
    chk("rst_tick", int'(bus_a.tick), 0);
    chk("rst_cur_div", int'(bus_a.cur_div), 4);
    chk("rst_level", int'(bus_a.level), 0);
    chk("rst_speed_max", int'(bus_a.speed_max), 0);

    // Start play straight out of reset.
    s = cyc;
    rst_n = 1'b1;
    bus_a.game_state = GS_START;
    bus_b.game_state = GS_START;
    push(s+5,  0, 4, 0, 0);
    push(s+10, 1, 3, 1, 0);
    push(s+14, 0, 3, 1, 0);
    push(s+18, 1, 2, 2, 1);
    push(s+21, 0, 2, 2, 1);
    push(s+24, 1, 2, 3, 1);
    push(s+27, 0, 2, 3, 1);
    push(s+30, 1, 2, 3, 1);
    push(s+40, 0, 2, 3, 1);  // 7 cycles late due to pause
    push(s+43, 1, 2, 3, 1);

    // Large step clamps to the floor on the first level-up.
    to_cyc(s+9);
    chk("b_cur_div_pre", int'(bus_b.cur_div), 4);
    to_cyc(s+10);
    chk("b_cur_div_clamp", int'(bus_b.cur_div), 2);
    chk("b_speed_max", int'(bus_b.speed_max), 1);
    chk("b_level", int'(bus_b.level), 1);
    bus_b.game_state = GS_END;

    to_cyc(s+31);
    bus_a.pause = 1'b1;
    to_cyc(s+35);
    chk("pause_clk_div_hold", int'(bus_a.clk_div), 1);
    to_cyc(s+38);
    bus_a.pause = 1'b0;

    to_cyc(s+44);
    bus_a.game_state = GS_END;
    for (int c = s + 45; c <= s + 56; c++) begin
      to_cyc(c);
      if (c == s + 50) bus_a.pause = 1'b1;
      chk("end_clk_div_idle", int'(bus_a.clk_div), idle_exp(c, s));
      chk("end_cur_div_hold", int'(bus_a.cur_div), 2);
      chk("end_level_hold", int'(bus_a.level), 3);
    end
    bus_a.game_state = GS_START;
    bus_a.pause = 1'b0;

    // Async reset mid-period, one cycle before a toggle was due.
    to_cyc(s+57);
    rst_n = 1'b0;
    #1;
    chk("async_rst_clk_div", int'(bus_a.clk_div), 1);
    chk("async_rst_tick", int'(bus_a.tick), 0);
    chk("async_rst_cur_div", int'(bus_a.cur_div), 4);
    chk("async_rst_level", int'(bus_a.level), 0);
    chk("async_rst_speed_max", int'(bus_a.speed_max), 0);
    repeat (2) @(negedge clk);
    u = cyc;
    rst_n = 1'b1;
    push(u+5,  0, 4, 0, 0);
    push(u+10, 1, 3, 1, 0);

    to_cyc(u+11);
    bus_a.game_state = GS_RESET;
    bus_a.pause = 1'b1;
    for (int c = u + 12; c <= u + 15; c++) begin
      to_cyc(c);
      chk("reset_cur_div", int'(bus_a.cur_div), 4);
      chk("reset_level", int'(bus_a.level), 0);
      chk("reset_speed_max", int'(bus_a.speed_max), 0);
      chk("reset_clk_div_idle", int'(bus_a.clk_div), idle_exp(c, u));
    end

    // Entering play keeps the current clk_div level; first toggle after a full half-period.
    v = cyc;
    hold = idle_exp(v, u);
    bus_a.game_state = GS_START;
    bus_a.pause = 1'b0;
    push(v+5, 1 - hold, 4, 0, 0);
    for (int c = v + 1; c <= v + 4; c++) begin
      to_cyc(c);
      chk("entry_clk_div_hold", int'(bus_a.clk_div), hold);
    end

    to_cyc(v+8);
    chk("pending_ticks", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
